// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, synchronous imem request, IF/ID register, one-entry skid buffer.
// Optional IF_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] o_stall_cycles,
   output logic [15:0] o_flush_count
`endif
);

   logic [31:0] pc_reg, pc_next;
   logic        run_reg;
   logic        pending_reg, pending_next;
   logic [31:0] pending_pc4_reg, pending_pc4_next;
   logic        skid_valid_reg, skid_valid_next;
   logic [31:0] skid_instr_reg, skid_instr_next;
   logic [31:0] skid_pc4_reg, skid_pc4_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc4_reg, pc4_next;
   logic        valid_reg, valid_next;
   logic        req;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_reg + 32'd4;

   always_comb begin
      req              = run_reg & ~i_stall & ~i_redirect;
      pc_next          = pc_reg;
      pending_next     = req;
      pending_pc4_next = pending_pc4_reg;
      skid_valid_next  = skid_valid_reg;
      skid_instr_next  = skid_instr_reg;
      skid_pc4_next    = skid_pc4_reg;
      instr_next       = instr_reg;
      pc4_next         = pc4_reg;
      valid_next       = valid_reg;

      if (i_redirect) begin
         pc_next = {i_redirect_pc[31:2], 2'b00};
      end else if (req) begin
         pc_next          = pc_plus4;
         pending_pc4_next = pc_plus4;
      end

      // IF/ID load priority: redirect, stall, skid, pending response, bubble
      if (i_redirect) begin
         skid_valid_next = 1'b0;
         valid_next      = 1'b0;
         instr_next      = 32'd0;
      end else if (i_stall) begin
         if (pending_reg) begin
            skid_valid_next = 1'b1;
            skid_instr_next = i_imem_rdata;
            skid_pc4_next   = pending_pc4_reg;
         end
      end else if (skid_valid_reg) begin
         instr_next      = skid_instr_reg;
         pc4_next        = skid_pc4_reg;
         valid_next      = 1'b1;
         skid_valid_next = 1'b0;
      end else if (pending_reg) begin
         instr_next = i_imem_rdata;
         pc4_next   = pending_pc4_reg;
         valid_next = 1'b1;
      end else begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pc_reg          <= RESET_PC;
         run_reg         <= 1'b0;
         pending_reg     <= 1'b0;
         pending_pc4_reg <= 32'd0;
         skid_valid_reg  <= 1'b0;
         skid_instr_reg  <= 32'd0;
         skid_pc4_reg    <= 32'd0;
         instr_reg       <= 32'd0;
         pc4_reg         <= 32'd0;
         valid_reg       <= 1'b0;
      end else begin
         pc_reg          <= pc_next;
         run_reg         <= 1'b1;
         pending_reg     <= pending_next;
         pending_pc4_reg <= pending_pc4_next;
         skid_valid_reg  <= skid_valid_next;
         skid_instr_reg  <= skid_instr_next;
         skid_pc4_reg    <= skid_pc4_next;
         instr_reg       <= instr_next;
         pc4_reg         <= pc4_next;
         valid_reg       <= valid_next;
      end
   end

   assign o_imem_req    = req;
   assign o_imem_addr   = pc_reg;
   assign o_instruction = instr_reg;
   assign o_pc_plus4    = pc4_reg;
   assign o_valid       = valid_reg;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic [15:0] flush_cnt_reg;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 16'd0;
      end else begin
         if (run_reg && i_stall && !i_redirect && !(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (i_redirect && !(&flush_cnt_reg))
            flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
   end

   assign o_stall_cycles = stall_cnt_reg;
   assign o_flush_count  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall/skid, redirect, wrap, async reset.
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] XMASK  = 32'hA5A5_0000;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'd0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_rdata = 32'd0;
   logic [31:0] o_instruction;
   logic [31:0] o_pc_plus4;
   logic        o_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] o_stall_cycles;
   logic [15:0] o_flush_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_rdata  (i_imem_rdata),
      .o_instruction (o_instruction),
      .o_pc_plus4    (o_pc_plus4),
      .o_valid       (o_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .o_stall_cycles(o_stall_cycles),
      .o_flush_count (o_flush_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   // synchronous instruction memory: word returned the cycle after the request
   always @(posedge i_clk) begin
      if (o_imem_req) i_imem_rdata <= o_imem_addr ^ XMASK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // checks the full fetch/IF-ID state for the current cycle
   task automatic expect_cycle(input string tag, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc4, input logic [31:0] ins);
      check({tag, ".req"},   {31'd0, o_imem_req}, {31'd0, req});
      check({tag, ".addr"},  o_imem_addr, addr);
      check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, vld});
      if (vld) begin
         check({tag, ".pc4"},   o_pc_plus4, pc4);
         check({tag, ".instr"}, o_instruction, ins);
      end
   endtask

   initial begin
      // reset state
      #12;
      expect_cycle("rst", 1'b0, RST_PC, 1'b0, 32'd0, 32'd0);
      check("rst.instr", o_instruction, 32'd0);
      check("rst.pc4", o_pc_plus4, 32'd0);
      tick();
      i_reset_n = 1'b1;
      #1;
      check("c0.req", {31'd0, o_imem_req}, 32'd0);

      // first fetches after release
      tick(); expect_cycle("c1", 1'b1, 32'h100, 1'b0, 32'd0, 32'd0);
      tick(); expect_cycle("c2", 1'b1, 32'h104, 1'b0, 32'd0, 32'd0);
      tick(); expect_cycle("c3", 1'b1, 32'h108, 1'b1, 32'h104, 32'hA5A5_0100);
      tick(); expect_cycle("c4", 1'b1, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0104);

      // three stall cycles; response for 0x108 goes to skid
      i_stall = 1'b1; #1;
      expect_cycle("s1", 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0104);
      tick(); expect_cycle("s2", 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0104);
      tick(); expect_cycle("s3", 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0104);
      tick();
      i_stall = 1'b0; #1;
      expect_cycle("rel", 1'b1, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0104);
      tick(); expect_cycle("skid", 1'b1, 32'h110, 1'b1, 32'h10C, 32'hA5A5_0108);
      tick(); expect_cycle("c9", 1'b1, 32'h114, 1'b1, 32'h110, 32'hA5A5_010C);

      // redirect with a response pending (0x110 must be dropped)
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_2003; #1;
      check("rd.req", {31'd0, o_imem_req}, 32'd0);
      tick();
      i_redirect = 1'b0; #1;
      expect_cycle("rd1", 1'b1, 32'h2000, 1'b0, 32'd0, 32'd0);
      check("rd1.instr", o_instruction, 32'd0);
      tick(); expect_cycle("rd2", 1'b1, 32'h2004, 1'b0, 32'd0, 32'd0);
      tick(); expect_cycle("rd3", 1'b1, 32'h2008, 1'b1, 32'h2004, 32'hA5A5_2000);

      // fill skid, then redirect + stall together
      i_stall = 1'b1; #1;
      tick();
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8; #1;
      check("rs.req", {31'd0, o_imem_req}, 32'd0);
      tick();
      i_redirect = 1'b0; i_stall = 1'b0; #1;
      expect_cycle("rs1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'd0);
      check("rs1.instr", o_instruction, 32'd0);
      tick(); expect_cycle("rs2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0);

      // address wrap
      tick(); expect_cycle("w1", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFF8);
      tick(); expect_cycle("w2", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h5A5A_FFFC);

`ifdef IF_PERF_CNT_EN
      check("perf.stall", o_stall_cycles, 32'd4);
      check("perf.flush", {16'd0, o_flush_count}, 32'd2);
`endif

      // async reset mid-stream during a stall with a response in flight
      i_stall = 1'b1;
      #3;
      i_reset_n = 1'b0;
      #1;
      expect_cycle("ar", 1'b0, RST_PC, 1'b0, 32'd0, 32'd0);
      check("ar.instr", o_instruction, 32'd0);
      check("ar.pc4", o_pc_plus4, 32'd0);
`ifdef IF_PERF_CNT_EN
      check("ar.stall", o_stall_cycles, 32'd0);
      check("ar.flush", {16'd0, o_flush_count}, 32'd0);
`endif
      tick();
      i_reset_n = 1'b1; i_stall = 1'b0; #1;
      check("ar0.req", {31'd0, o_imem_req}, 32'd0);
      tick(); expect_cycle("ar1", 1'b1, 32'h100, 1'b0, 32'd0, 32'd0);
      tick(); expect_cycle("ar2", 1'b1, 32'h104, 1'b0, 32'd0, 32'd0);
      tick(); expect_cycle("ar3", 1'b1, 32'h108, 1'b1, 32'h104, 32'hA5A5_0100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
